// File: rtl/ysyx_22050535_ctrl_fsm_pkg.sv
// Shared definitions for the RV32E multi-cycle sequencer: opcode constants,
// sequencer states, the ebreak encoding and the default reset PC.
package ysyx_22050535_ctrl_fsm_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // inst[31:7] of ebreak; every other SYSTEM encoding stops the core as illegal
   localparam logic [24:0] EBREAK_HI = 25'h0002000;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_IWAIT  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_MWAIT  = 3'd5,
      ST_WB     = 3'd6,
      ST_HALT   = 3'd7
   } state_t;

endpackage

// File: rtl/ysyx_22050535_ctrl_fsm_opc_class.sv
// Opcode classifier: tells the sequencer whether an opcode is one the core
// implements, whether it touches data memory, and whether it writes rd.
module ysyx_22050535_opc_class
   import ysyx_22050535_ctrl_fsm_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       legal,
   output logic       is_load,
   output logic       is_store,
   output logic       writes_rd
);

   // Table lookup; SYSTEM is legal but never reaches writeback, so writes_rd stays 0
   always_comb begin
      legal     = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      writes_rd = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
         end
         OPC_LOAD: begin
            legal     = 1'b1;
            is_load   = 1'b1;
            writes_rd = 1'b1;
         end
         OPC_STORE: begin
            legal    = 1'b1;
            is_store = 1'b1;
         end
         OPC_BRANCH, OPC_SYSTEM: begin
            legal = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/ysyx_22050535_ctrl_fsm.sv
// Multi-cycle sequencer for the RV32E core: fetch, decode classification,
// execute/memory/writeback stepping, PC and retired-instruction bookkeeping,
// and the sticky halt/illegal status seen by the simulation harness.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | imem request presented at pc, waiting for acceptance
// IWAIT  | request accepted, waiting for the instruction word
// DECODE | classify opcode: run it, or stop (ebreak / illegal)
// EXEC   | one settle cycle for the execute unit
// MEM    | data-memory request held until accepted
// MWAIT  | load accepted, waiting for the load data
// WB     | rd write, pc update, retire; misaligned target stops the core
// HALT   | core stopped until reset
module ysyx_22050535_ctrl_fsm
   import ysyx_22050535_ctrl_fsm_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_rsp_valid,
   input  logic [INST_WIDTH-1:0] imem_rsp_data,
   output logic [INST_WIDTH-1:0] inst,
   input  logic [6:0]            opcode,
   input  logic [DATA_WIDTH-1:0] exu_next_pc,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic                  dmem_req_we,
   input  logic                  dmem_rsp_valid,
   output logic                  rf_we,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [31:0]           instret,
   output logic                  halt,
   output logic                  illegal
);

   state_t state, state_d;

   logic                  legal, is_load, is_store, writes_rd;
   logic                  inst_we, pc_we, retire, enter_halt, set_illegal;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [INST_WIDTH-1:0] inst_q;
   logic [31:0]           instret_q;
   logic                  halt_q, illegal_q;

   ysyx_22050535_opc_class u_opc_class (
      .opcode    (opcode),
      .legal     (legal),
      .is_load   (is_load),
      .is_store  (is_store),
      .writes_rd (writes_rd)
   );

   // Next-state and Moore request outputs; rf_we only ever rises in WB
   always_comb begin
      state_d        = state;
      imem_req_valid = 1'b0;
      dmem_req_valid = 1'b0;
      dmem_req_we    = 1'b0;
      rf_we          = 1'b0;
      inst_we        = 1'b0;
      pc_we          = 1'b0;
      retire         = 1'b0;
      enter_halt     = 1'b0;
      set_illegal    = 1'b0;
      case (state)
         ST_FETCH: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) state_d = ST_IWAIT;
         end
         ST_IWAIT: begin
            if (imem_rsp_valid) begin
               inst_we = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (opcode == OPC_SYSTEM) begin
               enter_halt  = 1'b1;
               set_illegal = (inst_q[31:7] != EBREAK_HI);
               state_d     = ST_HALT;
            end else if (!legal) begin
               enter_halt  = 1'b1;
               set_illegal = 1'b1;
               state_d     = ST_HALT;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = (is_load || is_store) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            dmem_req_valid = 1'b1;
            dmem_req_we    = is_store;
            if (dmem_req_ready) state_d = is_store ? ST_WB : ST_MWAIT;
         end
         ST_MWAIT: begin
            if (dmem_rsp_valid) state_d = ST_WB;
         end
         ST_WB: begin
            rf_we  = writes_rd && (inst_q[11:7] != 5'd0);
            retire = 1'b1;
            if (exu_next_pc[1:0] != 2'b00) begin
               enter_halt  = 1'b1;
               set_illegal = 1'b1;
               state_d     = ST_HALT;
            end else begin
               pc_we   = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_HALT: begin
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // State, PC, instruction latch, retire counter and sticky status
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FETCH;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         instret_q <= '0;
         halt_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state <= state_d;
         if (inst_we)     inst_q    <= imem_rsp_data;
         if (pc_we)       pc_q      <= exu_next_pc;
         if (retire)      instret_q <= instret_q + 32'd1;
         if (enter_halt)  halt_q    <= 1'b1;
         if (set_illegal) illegal_q <= 1'b1;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign inst      = inst_q;
   assign instret   = instret_q;
   assign halt      = halt_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_ysyx_22050535_ctrl_fsm.sv
// Self-checking bench for the RV32E sequencer. A reactive memory environment
// answers fetch and load/store requests with chosen wait counts; a per-
// instruction reference model predicts cycle counts, rf_we, pc, instret and
// the halt/illegal status from the instruction class and the wait counts.
module tb_ysyx_22050535_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] inst;
   logic [6:0]  opcode;
   logic [31:0] exu_next_pc;
   logic        dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_rsp_valid;
   logic        rf_we;
   logic [31:0] pc, instret;
   logic        halt, illegal;

   int tests = 0;
   int fails = 0;

   logic [31:0] m_pc, m_instret;

   always #5 clk = ~clk;

   // The bench plays the decode unit: opcode is the low field of the latched word
   assign opcode = inst[6:0];

   ysyx_22050535_ctrl_fsm dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst           (inst),
      .opcode         (opcode),
      .exu_next_pc    (exu_next_pc),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_req_we    (dmem_req_we),
      .dmem_rsp_valid (dmem_rsp_valid),
      .rf_we          (rf_we),
      .pc             (pc),
      .instret        (instret),
      .halt           (halt),
      .illegal        (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Instruction classes straight from the ISA opcode map
   function automatic void classify(input logic [6:0] op, output bit legal,
                                    output bit ld, output bit st, output bit br,
                                    output bit sys);
      legal = 1'b1; ld = 1'b0; st = 1'b0; br = 1'b0; sys = 1'b0;
      case (op)
         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
         7'b0010011, 7'b0110011: ;
         7'b1100011: br  = 1'b1;
         7'b0000011: ld  = 1'b1;
         7'b0100011: st  = 1'b1;
         7'b1110011: sys = 1'b1;
         default:    legal = 1'b0;
      endcase
   endfunction

   task automatic idle_inputs();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      exu_next_pc    = '0;
   endtask

   // Reset from wherever the core is; returns on a falling edge with the core in FETCH
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_pc      = 32'h8000_0000;
      m_instret = 32'd0;
      chk({tag, "/pc"},        pc,             32'h8000_0000);
      chk({tag, "/instret"},   instret,        32'd0);
      chk({tag, "/inst"},      inst,           32'd0);
      chk({tag, "/halt"},      {31'd0, halt},           32'd0);
      chk({tag, "/illegal"},   {31'd0, illegal},        32'd0);
      chk({tag, "/imem_req"},  {31'd0, imem_req_valid}, 32'd1);
      chk({tag, "/dmem_req"},  {31'd0, dmem_req_valid}, 32'd0);
      chk({tag, "/rf_we"},     {31'd0, rf_we},          32'd0);
   endtask

   // Run one instruction starting at a falling edge in FETCH. fw/rw: fetch accept
   // and response waits; dw/lw: data accept and load response waits. abort_at>0
   // returns at that cycle before driving inputs, leaving the core mid-flight.
   task automatic run_inst(input string tag, input logic [31:0] word,
                           input logic [31:0] npc, input int fw, input int rw,
                           input int dw, input int lw, input int abort_at);
      bit legal, ld, st, br, sys, dec_halt, exp_ill, misal, exp_rf;
      bit i_acc, i_done, d_acc, d_done, fin;
      int cyc, rf_cnt, rf_at, dreq_cyc, we_bad, end_cyc, mem, wb_cyc, exp_end;
      int fc, rc, dc, lc;
      classify(word[6:0], legal, ld, st, br, sys);
      dec_halt = !legal || sys;
      exp_ill  = !legal || (sys && (word[31:7] != 25'h0002000));
      misal    = !dec_halt && (npc[1:0] != 2'b00);
      exp_rf   = !dec_halt && !br && !st && (word[11:7] != 5'd0);
      mem      = ld ? (dw + 1 + lw + 1) : (st ? dw + 1 : 0);
      wb_cyc   = fw + rw + 5 + mem;
      exp_end  = dec_halt ? fw + rw + 4 : wb_cyc + 1;
      i_acc = 0; i_done = 0; d_acc = 0; d_done = 0; fin = 0;
      cyc = 0; rf_cnt = 0; rf_at = 0; dreq_cyc = 0; we_bad = 0; end_cyc = 0;
      fc = fw; rc = rw; dc = dw; lc = lw;
      while (!fin) begin
         cyc++;
         if (cyc == 1) begin
            chk({tag, "/imem_addr"},  imem_addr, m_pc);
            chk({tag, "/imem_valid"}, {31'd0, imem_req_valid}, 32'd1);
         end
         if (abort_at != 0 && cyc == abort_at) return;
         if (rf_we) begin
            rf_cnt++;
            rf_at = cyc;
         end
         if (dmem_req_valid) begin
            dreq_cyc++;
            if (dmem_req_we !== st) we_bad++;
         end
         if (cyc > 1 && (halt || (imem_req_valid && i_done))) begin
            fin = 1; end_cyc = cyc;
         end else if (cyc > 200) begin
            fin = 1; end_cyc = cyc;
         end else begin
            logic [31:0] r;
            r = $urandom;
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = r;
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            exu_next_pc    = npc;
            if (imem_req_valid && !i_acc) begin
               if (fc == 0) begin
                  imem_req_ready = 1'b1;
                  i_acc = 1;
               end else fc--;
            end else if (i_acc && !i_done) begin
               if (rc == 0) begin
                  imem_rsp_valid = 1'b1;
                  imem_rsp_data  = word;
                  i_done = 1;
               end else rc--;
            end else if (i_done) begin
               // stray responses after the fetch completed must be ignored
               imem_rsp_valid = r[0];
            end
            if (dmem_req_valid && !d_acc) begin
               if (dc == 0) begin
                  dmem_req_ready = 1'b1;
                  d_acc = 1;
               end else dc--;
            end else if (d_acc && ld && !d_done) begin
               if (lc == 0) begin
                  dmem_rsp_valid = 1'b1;
                  d_done = 1;
               end else lc--;
            end
            @(negedge clk);
         end
      end
      chk({tag, "/end_cycle"}, end_cyc, exp_end);
      chk({tag, "/rf_we_count"}, rf_cnt, exp_rf ? 32'd1 : 32'd0);
      if (exp_rf) chk({tag, "/rf_we_cycle"}, rf_at, wb_cyc);
      chk({tag, "/dmem_req_cycles"}, dreq_cyc, (ld || st) ? dw + 1 : 0);
      chk({tag, "/dmem_we_stable"}, we_bad, 32'd0);
      if (!dec_halt) begin
         m_instret = m_instret + 32'd1;
         if (!misal) m_pc = npc;
      end
      chk({tag, "/pc"},      pc,      m_pc);
      chk({tag, "/instret"}, instret, m_instret);
      chk({tag, "/inst"},    inst,    word);
      chk({tag, "/halt"},    {31'd0, halt},    {31'd0, dec_halt || misal});
      chk({tag, "/illegal"}, {31'd0, illegal}, {31'd0, exp_ill || misal});
   endtask

   initial begin
      logic [6:0]  ops [9];
      logic [31:0] w, r, npc;
      int          n_imem, n_dmem, n_rf;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
      rst = 1'b1;
      idle_inputs();
      m_pc = 32'h8000_0000;
      m_instret = 32'd0;

      do_reset("reset0");

      // addi x1,x0,5 at zero wait: rf_we at cycle 5
      run_inst("addi", 32'h0050_0093, 32'h8000_0004, 0, 0, 0, 0, 0);
      // load with three stall cycles on the data request: 10 cycles
      run_inst("load_stall", 32'h0000_A103, m_pc + 32'd4, 0, 0, 3, 0, 0);
      // store: writeback straight after accept, no rf write
      run_inst("store", 32'h0020_A023, m_pc + 32'd4, 0, 0, 0, 0, 0);

      // random instruction stream with random waits and aligned targets
      for (int i = 0; i < 40; i++) begin
         w = $urandom;
         w[6:0] = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 4) == 0) w[11:7] = 5'd0;
         r = $urandom;
         npc = {r[31:2], 2'b00};
         run_inst("rand", w, npc, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

      // ebreak: clean halt, then the core must stay quiet
      run_inst("ebreak", 32'h0010_0073, m_pc + 32'd4, 1, 1, 0, 0, 0);
      n_imem = 0; n_dmem = 0; n_rf = 0;
      for (int i = 0; i < 20; i++) begin
         imem_req_ready = 1'b1;
         imem_rsp_valid = 1'($urandom_range(0, 1));
         dmem_req_ready = 1'b1;
         dmem_rsp_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (imem_req_valid) n_imem++;
         if (dmem_req_valid) n_dmem++;
         if (rf_we) n_rf++;
      end
      idle_inputs();
      chk("halted/imem_req", n_imem, 32'd0);
      chk("halted/dmem_req", n_dmem, 32'd0);
      chk("halted/rf_we",    n_rf,   32'd0);
      chk("halted/pc",       pc,     m_pc);
      chk("halted/halt",     {31'd0, halt}, 32'd1);

      do_reset("reset1");
      run_inst("unknown_opc", 32'h0000_007F, 32'h8000_0004, 0, 0, 0, 0, 0);
      do_reset("reset2");
      run_inst("ecall", 32'h0000_0073, 32'h8000_0004, 0, 2, 0, 0, 0);
      do_reset("reset3");
      run_inst("misaligned", 32'h0050_0093, 32'h8000_0006, 0, 0, 0, 0, 0);

      // reset while a load waits for its data, with the data arriving late
      do_reset("reset4");
      run_inst("abort_load", 32'h0000_A103, 32'h8000_0004, 0, 0, 0, 50, 7);
      rst = 1'b1;
      idle_inputs();
      dmem_rsp_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_pc = 32'h8000_0000;
      m_instret = 32'd0;
      chk("mid_rst/pc",        pc,      32'h8000_0000);
      chk("mid_rst/instret",   instret, 32'd0);
      chk("mid_rst/rf_we",     {31'd0, rf_we},          32'd0);
      chk("mid_rst/imem_req",  {31'd0, imem_req_valid}, 32'd1);
      @(negedge clk);
      chk("stale_rsp/rf_we",    {31'd0, rf_we},          32'd0);
      chk("stale_rsp/imem_req", {31'd0, imem_req_valid}, 32'd1);
      chk("stale_rsp/dmem_req", {31'd0, dmem_req_valid}, 32'd0);
      dmem_rsp_valid = 1'b0;
      run_inst("after_rst", 32'h0050_0093, 32'h8000_0004, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ysyx_22050535_ctrl_fsm.md
Name: ysyx_22050535_ctrl_fsm

Overview:
Multi-cycle sequencer for the single-issue RV32E core. It fetches each instruction over a valid/ready instruction-memory port and latches it for the decode unit. It then classifies the decoded opcode and steps the instruction through execute, memory and writeback, driving register-file and PC write enables. It owns the PC, the retired-instruction counter and the halt/illegal status reported to the simulation harness.

Parameters:
DATA_WIDTH, 32, datapath/address width
INST_WIDTH, 32, instruction width
RESET_PC, 32'h8000_0000, PC value loaded on reset

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  fetch request accepted
imem_addr  out  DATA_WIDTH  fetch address (= pc)
imem_rsp_valid  in  1  fetch data valid
imem_rsp_data  in  INST_WIDTH  fetched instruction
inst  out  INST_WIDTH  latched instruction to decode unit
opcode  in  7  opcode from decode unit
exu_next_pc  in  DATA_WIDTH  next PC computed by execute unit
dmem_req_valid  out  1  load/store request valid
dmem_req_ready  in  1  load/store request accepted
dmem_req_we  out  1  1 = store, 0 = load
dmem_rsp_valid  in  1  load data valid
rf_we  out  1  register-file write enable (one cycle)
pc  out  DATA_WIDTH  current PC
instret  out  32  retired-instruction count
halt  out  1  sticky: core stopped
illegal  out  1  sticky: stop caused by illegal instruction/misaligned PC

Behaviour:
- Clock and reset: one clock, clk; rst synchronous, active-high. rst forces state=FETCH, pc=RESET_PC, inst=0, instret=0, halt=0, illegal=0, and all valid/we outputs 0, from any state, including mid-handshake. Outstanding responses are dropped.
- States: FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT.
- FETCH: imem_req_valid=1, imem_addr=pc. On imem_req_ready -> IWAIT.
- IWAIT: on imem_rsp_valid, inst<=imem_rsp_data -> DECODE. Memory contract: the response arrives no earlier than the cycle after acceptance. imem_rsp_valid in any other state is ignored.
- DECODE: classify opcode.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 1110011.
  - SYSTEM with inst[31:7]==25'h0002000 (ebreak) -> HALT, halt=1, illegal=0.
  - Any other SYSTEM encoding or unknown opcode -> HALT, halt=1, illegal=1.
  - All other legal opcodes -> EXEC.
- EXEC: one cycle for execute-unit settle. LOAD/STORE -> MEM; else -> WB.
- MEM: dmem_req_valid=1, dmem_req_we=(opcode==STORE), both held stable until dmem_req_ready. On accept: store -> WB, load -> MWAIT.
- MWAIT: wait for dmem_rsp_valid -> WB.
- WB (one cycle):
  - rf_we=1 unless opcode is BRANCH or STORE, or inst[11:7]==0.
  - pc<=exu_next_pc; instret<=instret+1, wrapping modulo 2^32.
  - If exu_next_pc[1:0]!=0: pc is not updated, instret still increments, -> HALT with illegal=1. Otherwise -> FETCH.
- HALT: all requests 0, rf_we 0. Stays until rst; halt/illegal held.
- Latency at zero-wait memory (ready=1, response 1 cycle later): ALU/branch/jump 5 cycles, store 6, load 7.
- Request outputs are Moore (state-decoded). rf_we is asserted only in WB.

Decomposition:
- Shared defines file: opcode constants (OPC_LUI … OPC_SYSTEM), state encodings, EBREAK encoding, RESET_PC default.
- One combinational sub-module, ysyx_22050535_opc_class: opcode -> {legal, is_load, is_store, writes_rd}. The FSM, PC and instret counter stay in the top module.

Test Plan:
- Reset then zero-wait imem returning 0x00500093 (addi x1,x0,5): imem_addr=0x80000000; rf_we=1 exactly at cycle 5; pc=0x80000004; instret=1.
- Load 0x0000A103 with dmem_req_ready held 0 for 3 cycles: dmem_req_valid/we=1/0 stable across the stall; rf_we pulses once after dmem_rsp_valid; total 10 cycles.
- Store 0x0020A023: dmem_req_we=1, WB reached on accept, rf_we=0; instret increments.
- ebreak 0x00100073: halt=1, illegal=0, no further imem_req_valid for 20 cycles. Unknown opcode 0x0000007F: halt=1, illegal=1.
- exu_next_pc=0x80000006 in WB: halt=1, illegal=1, pc remains 0x80000000.
- rst asserted while in MWAIT with a late dmem_rsp_valid: next cycle state FETCH, pc=RESET_PC, the stale response is ignored, rf_we=0.
